// File: rtl/aging_uart_pkg.sv
// rtl/aging_uart_pkg.sv - shared state encoding and default constants for the UART transmitter
package aging_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned DEF_CLK_DIV    = 868;
  localparam int unsigned DEF_FIFO_DEPTH = 16;

endpackage

// File: rtl/aging_uart_fifo.sv
// rtl/aging_uart_fifo.sv - byte FIFO with registered occupancy count and full/empty flags
module aging_uart_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  // Storage needs no reset: contents are only visible through count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/aging_uart_tx.sv
// rtl/aging_uart_tx.sv - FIFO-buffered 8N1 UART transmitter with sticky overflow flag
module aging_uart_tx
  import aging_uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] UartData_i,
  input  logic       UartTrans_i,
  output logic       UartBusy_o,
  output logic       UartEmpty_o,
  output logic       Overflow_o,
  output logic       Tx_o
);

  tx_state_e   state, state_nx;
  logic [15:0] baud, baud_nx;
  logic [2:0]  bit_idx, bit_nx;
  logic [7:0]  shreg, sh_nx;
  logic        tx_nx;
  logic        accept, pop, full, empty, baud_term;
  logic [7:0]  head;

  // Busy comes from the registered count, so a same-cycle pop never admits a write.
  assign accept    = UartTrans_i && !full;
  assign baud_term = (baud == 16'(CLK_DIV - 1));

  aging_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (accept),
    .push_data (UartData_i),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    state_nx = state;
    baud_nx  = baud;
    bit_nx   = bit_idx;
    sh_nx    = shreg;
    pop      = 1'b0;
    tx_nx    = 1'b1;
    case (state)
      IDLE: begin
        baud_nx = '0;
        bit_nx  = '0;
        if (!empty) begin
          pop      = 1'b1;
          sh_nx    = head;
          state_nx = START;
        end
      end
      START: begin
        tx_nx = 1'b0;
        if (baud_term) begin
          baud_nx  = '0;
          state_nx = DATA;
        end else begin
          baud_nx = baud + 16'd1;
        end
      end
      DATA: begin
        tx_nx = shreg[0];
        if (baud_term) begin
          baud_nx = '0;
          sh_nx   = {1'b0, shreg[7:1]};
          bit_nx  = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nx = STOP;
        end else begin
          baud_nx = baud + 16'd1;
        end
      end
      STOP: begin
        tx_nx = 1'b1;
        if (baud_term) begin
          baud_nx  = '0;
          state_nx = IDLE;
        end else begin
          baud_nx = baud + 16'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Line level is registered from the current state, so it trails the state by one cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      baud       <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      Tx_o       <= 1'b1;
      Overflow_o <= 1'b0;
    end else begin
      state      <= state_nx;
      baud       <= baud_nx;
      bit_idx    <= bit_nx;
      shreg      <= sh_nx;
      Tx_o       <= tx_nx;
      Overflow_o <= Overflow_o | (UartTrans_i && full);
    end
  end

  assign UartBusy_o  = full;
  assign UartEmpty_o = empty && (state == IDLE);

endmodule

// File: tb/tb_aging_uart_tx.sv
// tb/tb_aging_uart_tx.sv - self-checking bench: vector table, serial-line scoreboard, corner sequences
module tb_aging_uart_tx;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] data, data2;
  logic       trans, trans2;
  logic       busy, empty, ovf, tx;
  logic       busy2, empty2, ovf2, tx2;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int rx_cnt [2];
  bit rst_hit [2];
  logic [7:0] exp_q0 [$];
  logic [7:0] exp_q1 [$];
  int starts [$];

  typedef struct {
    logic [7:0] data;
    int         fall_lat;
    int         empty_lat;
  } vec_t;
  vec_t vecs [5];

  logic [7:0] burst [10];

  aging_uart_tx #(.CLK_DIV(4), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .rstn(rstn), .UartData_i(data), .UartTrans_i(trans),
    .UartBusy_o(busy), .UartEmpty_o(empty), .Overflow_o(ovf), .Tx_o(tx)
  );

  aging_uart_tx #(.CLK_DIV(868), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rstn(rstn), .UartData_i(data2), .UartTrans_i(trans2),
    .UartBusy_o(busy2), .UartEmpty_o(empty2), .Overflow_o(ovf2), .Tx_o(tx2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge rstn) begin
    rst_hit[0] = 1'b1;
    rst_hit[1] = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic line(input bit sel);
    return sel ? tx2 : tx;
  endfunction

  // Decodes one 8N1 frame per falling edge, sampling mid-bit, and scores it against the queue.
  task automatic mon_run(input bit sel, input int div);
    logic [7:0] b;
    logic       start_ok, stop_bit;
    int         t0;
    forever begin
      @(negedge clk);
      if (rstn && line(sel) == 1'b0) begin
        t0 = cyc;
        rst_hit[sel] = 1'b0;
        repeat (div / 2) @(negedge clk);
        start_ok = (line(sel) == 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (div) @(negedge clk);
          b[i] = line(sel);
        end
        repeat (div) @(negedge clk);
        stop_bit = line(sel);
        if (!rst_hit[sel]) begin
          if (sel == 1'b0) starts.push_back(t0);
          chk($sformatf("start_bit%0d", sel), start_ok, 1);
          chk($sformatf("stop_bit%0d", sel), stop_bit, 1);
          if ((sel ? exp_q1.size() : exp_q0.size()) == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_frame%0d: got 0x%0h expected none", sel, b);
          end else begin
            chk($sformatf("rx_byte%0d", sel), b, sel ? exp_q1.pop_front() : exp_q0.pop_front());
          end
          rx_cnt[sel]++;
        end
      end
    end
  endtask

  task automatic wait_rx(input int sel, input int n, input int budget);
    int t = 0;
    while (rx_cnt[sel] < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("rx_done%0d", sel), rx_cnt[sel] >= n, 1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  initial mon_run(1'b0, 4);
  initial mon_run(1'b1, 868);

  initial begin
    int a0, lowcnt, base;
    int idx, g;
    rx_cnt[0] = 0;
    rx_cnt[1] = 0;
    rstn = 1'b0; trans = 1'b0; trans2 = 1'b0; data = '0; data2 = '0;
    vecs[0] = '{8'h15, 2, 41};
    vecs[1] = '{8'hA5, 2, 41};
    vecs[2] = '{8'h00, 2, 41};
    vecs[3] = '{8'hFF, 2, 41};
    vecs[4] = '{8'h80, 2, 41};
    burst = '{8'h05, 8'h13, 8'h21, 8'h2F, 8'h3D, 8'h4B, 8'h59, 8'h67, 8'h75, 8'h9F};

    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ovf", ovf, 0);
    chk("rst_tx2", tx2, 1);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Single frames from idle: start-bit latency and empty timing.
    foreach (vecs[v]) begin
      data = vecs[v].data;
      trans = 1'b1;
      exp_q0.push_back(vecs[v].data);
      @(posedge clk);
      @(negedge clk);
      trans = 1'b0;
      chk("busy_after_write", busy, 0);
      for (int k = 0; k < 46; k++) begin
        if (k == vecs[v].fall_lat - 1)  chk("tx_pre_fall", tx, 1);
        if (k == vecs[v].fall_lat)      chk("tx_fall", tx, 0);
        if (k == vecs[v].empty_lat - 1) chk("empty_pre", empty, 0);
        if (k == vecs[v].empty_lat)     chk("empty_rise", empty, 1);
        @(negedge clk);
      end
    end
    wait_rx(0, 5, 100);

    // Ten writes honouring busy: order and back-to-back period.
    starts.delete();
    base = rx_cnt[0];
    idx = 0;
    g = 0;
    while (idx < 10 && g < 1000) begin
      @(negedge clk);
      g++;
      if (!busy) begin
        data = burst[idx];
        trans = 1'b1;
        exp_q0.push_back(burst[idx]);
        idx++;
      end else begin
        trans = 1'b0;
      end
    end
    @(negedge clk);
    trans = 1'b0;
    chk("burst_all_written", idx, 10);
    wait_rx(0, base + 10, 600);
    chk("burst_frames", starts.size(), 10);
    for (int i = 1; i < starts.size(); i++) chk("frame_period", starts[i] - starts[i-1], 41);
    chk("burst_ovf", ovf, 0);

    // Five back-to-back writes while a frame is active: the fifth is dropped.
    base = rx_cnt[0];
    @(negedge clk);
    data = 8'h3C;
    trans = 1'b1;
    exp_q0.push_back(8'h3C);
    @(negedge clk);
    trans = 1'b0;
    repeat (3) @(negedge clk);
    for (int j = 0; j < 5; j++) begin
      chk("busy_before_write", busy, (j == 4) ? 1 : 0);
      if (j == 4) chk("ovf_before_drop", ovf, 0);
      data = 8'h40 + 8'(j);
      trans = 1'b1;
      if (j < 4) exp_q0.push_back(8'h40 + 8'(j));
      @(negedge clk);
    end
    trans = 1'b0;
    chk("ovf_set", ovf, 1);
    wait_rx(0, base + 5, 400);
    chk("ovf_sticky", ovf, 1);

    // Full FIFO with a write on the exact IDLE pop cycle.
    pulse_reset();
    chk("ovf_cleared", ovf, 0);
    base = rx_cnt[0];
    data = 8'h11;
    trans = 1'b1;
    exp_q0.push_back(8'h11);
    @(posedge clk);
    @(negedge clk);
    trans = 1'b0;
    a0 = cyc;
    repeat (2) @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      data = 8'hA0 + 8'(j);
      trans = 1'b1;
      exp_q0.push_back(8'hA0 + 8'(j));
      @(negedge clk);
    end
    trans = 1'b0;
    chk("fifo_full_busy", busy, 1);
    g = 0;
    while (cyc < a0 + 41 && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("busy_at_pop", busy, 1);
    data = 8'hEE;
    trans = 1'b1;
    @(posedge clk);
    @(negedge clk);
    trans = 1'b0;
    chk("busy_after_pop", busy, 0);
    chk("count_after_pop", 32'(dut0.u_fifo.count), 3);
    chk("ovf_pop_drop", ovf, 1);
    wait_rx(0, base + 5, 400);

    // Reset during data bit 3 aborts the frame and discards the FIFO.
    pulse_reset();
    data = 8'h5A;
    trans = 1'b1;
    exp_q0.push_back(8'h5A);
    @(posedge clk);
    @(negedge clk);
    trans = 1'b0;
    repeat (19) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("abort_tx", tx, 1);
    chk("abort_empty", empty, 1);
    chk("abort_busy", busy, 0);
    chk("abort_ovf", ovf, 0);
    exp_q0.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    lowcnt = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (tx == 1'b0) lowcnt++;
    end
    chk("no_frame_after_reset", lowcnt, 0);
    chk("idle_after_reset", empty, 1);
    base = rx_cnt[0];
    data = 8'hC3;
    trans = 1'b1;
    exp_q0.push_back(8'hC3);
    @(negedge clk);
    trans = 1'b0;
    wait_rx(0, base + 1, 100);

    // Full-rate divider: 0xA5 through the monitor.
    @(negedge clk);
    data2 = 8'hA5;
    trans2 = 1'b1;
    exp_q1.push_back(8'hA5);
    @(negedge clk);
    trans2 = 1'b0;
    wait_rx(1, 1, 9500);
    repeat (500) @(negedge clk);
    chk("slow_empty", empty2, 1);
    chk("slow_ovf", ovf2, 0);

    chk("q0_drained", exp_q0.size(), 0);
    chk("q1_drained", exp_q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
